// File: rtl/lsu_axi_lite_master_pkg.sv
// Shared types and codes for the LSU to AXI4-Lite bridge.
// Imported by the bridge top and its lane aligner.
package lsu_axi_lite_master_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] FLT_OK    = 2'b00;
  localparam logic [1:0] FLT_MISAL = 2'b01;
  localparam logic [1:0] FLT_BUS   = 2'b10;
  localparam logic [1:0] FLT_SIZE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP
  } lsu_state_e;

  function automatic logic resp_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/lsu_axi_lite_master_lane_align.sv
// Byte-lane steering: store shift and strobes,
// load shift with sign/zero extension.
module lsu_lane_align
  import lsu_axi_lite_master_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int SW = DATA_W / 8,
  localparam int OW = $clog2(SW)
) (
  input  logic [OW-1:0]     off,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [SW-1:0]     wstrb,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [OW+2:0]     bit_sh;
  logic [SW-1:0]     base;
  logic [DATA_W-1:0] rsh;

  assign bit_sh = {off, 3'b000};

  // store lanes: data and strobe shifted up to the byte offset
  always_comb begin
    base = '1;
    case (funct3[1:0])
      2'b00:   base = SW'(1);
      2'b01:   base = SW'(3);
      2'b10:   base = SW'(15);
      default: base = '1;
    endcase
    wdata_sh = wdata << bit_sh;
    wstrb    = base << off;
  end

  // load lanes: shift down, then extend to register width
  always_comb begin
    rsh       = rdata >> bit_sh;
    rdata_ext = rsh;
    case (funct3)
      F3_B:    rdata_ext = DATA_W'($signed(rsh[7:0]));
      F3_H:    rdata_ext = DATA_W'($signed(rsh[15:0]));
      F3_W:    rdata_ext = DATA_W'($signed(rsh[31:0]));
      F3_BU:   rdata_ext = DATA_W'(rsh[7:0]);
      F3_HU:   rdata_ext = DATA_W'(rsh[15:0]);
      F3_WU:   rdata_ext = DATA_W'(rsh[31:0]);
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_axi_lite_master.sv
// LSU request port to AXI4-Lite master bridge.
// One outstanding access; faults bypass the bus.
module lsu_axi_lite_master
  import lsu_axi_lite_master_pkg::*;
#(
  parameter int         DATA_W = 64,
  parameter int         ADDR_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_fault,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  localparam int SW = DATA_W / 8;
  localparam int OW = $clog2(SW);

  lsu_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     wstrb_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              arvalid_q;
  logic              aw_done;
  logic              w_done;
  logic              b_done;
  logic              b_err;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_fault_q;

  logic [OW-1:0]     off_sel;
  logic [2:0]        f3_sel;
  logic [DATA_W-1:0] wdata_sh;
  logic [SW-1:0]     wstrb;
  logic [DATA_W-1:0] rdata_ext;
  logic              illegal;
  logic              misal;
  logic [2:0]        amask;
  logic              aw_hs;
  logic              w_hs;
  logic              aw_all;
  logic              w_all;
  logic              b_all;
  logic              b_bad;

  // request fields while idle, latched access afterwards
  assign off_sel = (state == ST_IDLE) ?
                   req_addr[OW-1:0] : addr_q[OW-1:0];
  assign f3_sel  = (state == ST_IDLE) ? req_funct3 : f3_q;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .off       (off_sel),
    .funct3    (f3_sel),
    .wdata     (req_wdata),
    .rdata     (M_AXI_RDATA),
    .wdata_sh  (wdata_sh),
    .wstrb     (wstrb),
    .rdata_ext (rdata_ext)
  );

  // size legality and natural alignment of the new request
  always_comb begin
    illegal = (req_store && req_funct3[2]) ||
              (!req_store && req_funct3 == 3'b111) ||
              (DATA_W == 32 && req_funct3[1:0] == 2'b11);
    amask = 3'b000;
    case (req_funct3[1:0])
      2'b00:   amask = 3'b000;
      2'b01:   amask = 3'b001;
      2'b10:   amask = 3'b011;
      default: amask = 3'b111;
    endcase
    misal = |(req_addr[2:0] & amask);
  end

  assign aw_hs  = awvalid_q && M_AXI_AWREADY;
  assign w_hs   = wvalid_q && M_AXI_WREADY;
  assign aw_all = aw_done || aw_hs;
  assign w_all  = w_done || w_hs;
  assign b_all  = b_done || M_AXI_BVALID;
  assign b_bad  = b_done ? b_err : resp_err(M_AXI_BRESP);

  // access sequencer with registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      b_done      <= 1'b0;
      b_err       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= FLT_OK;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            f3_q    <= req_funct3;
            wdata_q <= wdata_sh;
            wstrb_q <= wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            b_done  <= 1'b0;
            b_err   <= 1'b0;
            if (illegal) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_fault_q <= FLT_SIZE;
            end else if (misal) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_fault_q <= FLT_MISAL;
            end else if (req_store) begin
              state     <= ST_WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= ST_RD;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (M_AXI_BVALID && !b_done) begin
            b_done <= 1'b1;
            b_err  <= resp_err(M_AXI_BRESP);
          end
          if (aw_all && w_all && b_all) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_fault_q <= b_bad ? FLT_BUS : FLT_OK;
          end
        end
        ST_RD: begin
          if (M_AXI_ARREADY) arvalid_q <= 1'b0;
          if (M_AXI_RVALID) begin
            arvalid_q   <= 1'b0;
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            if (resp_err(M_AXI_RRESP)) begin
              rsp_rdata_q <= '0;
              rsp_fault_q <= FLT_BUS;
            end else begin
              rsp_rdata_q <= rdata_ext;
              rsp_fault_q <= FLT_OK;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state == ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_fault     = rsp_fault_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state == ST_WR);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state == ST_RD);

endmodule

// File: tb/tb_lsu_axi_lite_master.sv
// Bench for lsu_axi_lite_master: 64-bit and 32-bit
// instances driven by a cycle-stepped AXI slave model.
module tb_lsu_axi_lite_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 64-bit instance
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_fault;
  logic [31:0] m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready;
  logic [63:0] m_wdata, m_rdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  lsu_axi_lite_master #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot),
    .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
    .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid),
    .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot),
    .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
    .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
    .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
  );

  // 32-bit instance
  logic        s_req_valid, s_req_ready, s_req_store;
  logic [2:0]  s_req_funct3;
  logic [31:0] s_req_addr, s_req_wdata;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic [1:0]  s_rsp_fault;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_wvalid, s_bvalid, s_bready;
  logic        s_arvalid, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;

  lsu_axi_lite_master #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_store(s_req_store), .req_funct3(s_req_funct3),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
    .rsp_fault(s_rsp_fault),
    .M_AXI_AWADDR(s_awaddr), .M_AXI_AWPROT(s_awprot),
    .M_AXI_AWVALID(s_awvalid), .M_AXI_AWREADY(1'b1),
    .M_AXI_WDATA(s_wdata), .M_AXI_WSTRB(s_wstrb),
    .M_AXI_WVALID(s_wvalid), .M_AXI_WREADY(1'b1),
    .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid),
    .M_AXI_BREADY(s_bready),
    .M_AXI_ARADDR(s_araddr), .M_AXI_ARPROT(s_arprot),
    .M_AXI_ARVALID(s_arvalid), .M_AXI_ARREADY(1'b1),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp),
    .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(s_rready)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] m_fault(
    input logic st, input logic [2:0] f3,
    input logic [31:0] a, input int dw);
    int nb;
    nb = nbytes(f3);
    if ((st && f3[2]) || (!st && f3 == 3'b111) ||
        (nb == 8 && dw == 32))
      return 2'b11;
    if ((a % nb) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_load(
    input logic [2:0] f3, input int off,
    input logic [63:0] bus, input int dw);
    logic [63:0] v, mask;
    int nb;
    nb = nbytes(f3);
    v = bus >> (8 * off);
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    end
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // ---------------- slave-side driver ----------------
  logic [63:0] o_rdata, o_wdata;
  logic [1:0]  o_fault;
  logic [7:0]  o_wstrb;
  logic [31:0] o_awaddr, o_araddr;
  int          o_lat, o_hs, o_aw_cnt, o_w_cnt;
  bit          o_aw_seen, o_ar_seen, o_timeout, o_pulse_ok;

  task automatic run_op(
    input logic st, input logic [2:0] f3,
    input logic [31:0] a, input logic [63:0] wd,
    input logic [63:0] rbus, input logic [1:0] resp,
    input int awd, input int wdl, input int bd,
    input int ard, input int rdl);
    int aw_hs, w_hs, ar_hs, last;
    bit b_done, r_done, done;
    aw_hs = -1; w_hs = -1; ar_hs = -1;
    b_done = 0; r_done = 0; done = 0;
    o_lat = -1; o_hs = -1; o_aw_cnt = 0; o_w_cnt = 0;
    o_aw_seen = 0; o_ar_seen = 0; o_pulse_ok = 0;
    o_rdata = '0; o_fault = '0; o_wdata = '0;
    o_wstrb = '0; o_awaddr = '0; o_araddr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    m_rdata = rbus; m_rresp = resp; m_bresp = resp;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      if (b_done) m_bvalid = 1'b0;
      if (r_done) m_rvalid = 1'b0;
      if (rsp_valid) begin
        o_lat = cyc; o_rdata = rsp_rdata;
        o_fault = rsp_fault; done = 1;
      end else begin
        if (m_awvalid) begin
          if (!o_aw_seen) o_awaddr = m_awaddr;
          o_aw_seen = 1; o_aw_cnt++;
          m_awready = (o_aw_cnt > awd);
          if (m_awready) aw_hs = cyc;
        end else m_awready = 1'b0;
        if (m_wvalid) begin
          if (o_w_cnt == 0) begin
            o_wdata = m_wdata; o_wstrb = m_wstrb;
          end
          o_w_cnt++;
          m_wready = (o_w_cnt > wdl);
          if (m_wready) w_hs = cyc;
        end else m_wready = 1'b0;
        last = (aw_hs > w_hs) ? aw_hs : w_hs;
        if (!b_done && aw_hs >= 0 && w_hs >= 0 &&
            cyc >= last + bd) begin
          m_bvalid = 1'b1;
          if (m_bready) begin b_done = 1; o_hs = cyc; end
        end
        if (m_arvalid) begin
          if (!o_ar_seen) o_araddr = m_araddr;
          o_ar_seen = 1;
          m_arready = (cyc > ard);
          if (m_arready) ar_hs = cyc;
        end else m_arready = 1'b0;
        if (!r_done && ar_hs >= 0 && cyc >= ar_hs + 1 + rdl) begin
          m_rvalid = 1'b1;
          if (m_rready) begin r_done = 1; o_hs = cyc; end
        end
        @(negedge clk);
      end
    end
    o_timeout = !done;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_rvalid = 0;
    if (done) begin
      @(negedge clk);
      o_pulse_ok = !rsp_valid && req_ready;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}
        !== 5'b0) begin
      errors++;
      $display("FAIL reset_axi: got %b want 00000",
        {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
    end
    checks++;
    if ({rsp_valid, rsp_fault, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %b %b %h want 0 00 0",
        rsp_valid, rsp_fault, rsp_rdata);
    end
    checks++;
    if ({s_req_ready, s_arvalid, s_rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_dw32: got %b want 100",
        {s_req_ready, s_arvalid, s_rsp_valid});
    end
  endtask

  task automatic test_load_lanes();
    logic [2:0]  f3s [3] = '{3'b001, 3'b010, 3'b110};
    logic [31:0] adrs[3] = '{32'h8000_0006, 32'h8000_0004,
                             32'h8000_0004};
    logic [63:0] bus [3] = '{64'h1122_3344_5566_7788,
                             64'hFFFF_FFFE_0000_0000,
                             64'hFFFF_FFFE_0000_0000};
    logic [63:0] exp [3] = '{64'h0000_0000_0000_1122,
                             64'hFFFF_FFFF_FFFF_FFFE,
                             64'h0000_0000_FFFF_FFFE};
    for (int i = 0; i < 3; i++) begin
      run_op(0, f3s[i], adrs[i], '0, bus[i], 2'b00, 0, 0, 0, 0, 0);
      checks++;
      if (o_timeout || o_rdata !== exp[i] || o_fault !== 2'b00) begin
        errors++;
        $display("FAIL load_%0d: got %h/%b want %h/00 (timeout %0d)",
          i, o_rdata, o_fault, exp[i], o_timeout);
      end
      checks++;
      if (o_lat !== o_hs + 1 || !o_pulse_ok) begin
        errors++;
        $display("FAIL load_lat_%0d: got lat %0d pulse %0d want %0d 1",
          i, o_lat, o_pulse_ok, o_hs + 1);
      end
    end
  endtask

  task automatic test_store_sh();
    run_op(1, 3'b001, 32'h8000_0002, 64'hABCD, '0, 2'b00,
           0, 0, 0, 0, 0);
    checks++;
    if (o_wdata !== 64'h0000_0000_ABCD_0000 || o_wstrb !== 8'h0C) begin
      errors++;
      $display("FAIL sh_lanes: got %h/%h want 00000000abcd0000/0c",
        o_wdata, o_wstrb);
    end
    checks++;
    if (o_timeout || o_fault !== 2'b00 ||
        o_awaddr !== 32'h8000_0002 || o_lat !== o_hs + 1) begin
      errors++;
      $display("FAIL sh_rsp: got f %b addr %h lat %0d want 00 80000002 %0d",
        o_fault, o_awaddr, o_lat, o_hs + 1);
    end
  endtask

  task automatic test_store_delay();
    run_op(1, 3'b010, 32'h8000_0008, 64'h1234_5678, '0, 2'b10,
           3, 0, 0, 0, 0);
    checks++;
    if (o_w_cnt !== 1 || o_aw_cnt !== 4) begin
      errors++;
      $display("FAIL sw_valids: got w %0d aw %0d want 1 4",
        o_w_cnt, o_aw_cnt);
    end
    checks++;
    if (o_timeout || o_fault !== 2'b10 || o_rdata !== '0) begin
      errors++;
      $display("FAIL sw_slverr: got %b/%h want 10/0",
        o_fault, o_rdata);
    end
  endtask

  task automatic test_faults();
    run_op(0, 3'b010, 32'h8000_0002, '0, 64'h55, 2'b00,
           0, 0, 0, 0, 0);
    checks++;
    if (o_ar_seen || o_fault !== 2'b01 || o_lat !== 1) begin
      errors++;
      $display("FAIL lw_misal: got ar %0d f %b lat %0d want 0 01 1",
        o_ar_seen, o_fault, o_lat);
    end
    run_op(1, 3'b100, 32'h8000_0000, '0, '0, 2'b00,
           0, 0, 0, 0, 0);
    checks++;
    if (o_aw_seen || o_fault !== 2'b11 || o_lat !== 1) begin
      errors++;
      $display("FAIL st_illegal: got aw %0d f %b lat %0d want 0 11 1",
        o_aw_seen, o_fault, o_lat);
    end
  endtask

  task automatic test_dw32();
    logic [2:0]  f3s[2] = '{3'b001, 3'b100};
    logic [31:0] ads[2] = '{32'h2, 32'h3};
    logic [63:0] exp;
    @(negedge clk);
    s_req_valid = 1; s_req_store = 0;
    s_req_funct3 = 3'b011; s_req_addr = 32'h0;
    @(negedge clk);
    s_req_valid = 0;
    checks++;
    if (!s_rsp_valid || s_rsp_fault !== 2'b11 || s_arvalid) begin
      errors++;
      $display("FAIL dw32_ld: got v %b f %b ar %b want 1 11 0",
        s_rsp_valid, s_rsp_fault, s_arvalid);
    end
    s_rdata = 32'hBEEF_1234;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_req_valid = 1; s_req_funct3 = f3s[i]; s_req_addr = ads[i];
      @(negedge clk);
      s_req_valid = 0;
      @(negedge clk);
      s_rvalid = 1;
      @(negedge clk);
      s_rvalid = 0;
      exp = m_load(f3s[i], int'(ads[i] % 4), {32'h0, s_rdata}, 32);
      checks++;
      if (!s_rsp_valid || s_rsp_rdata !== exp[31:0] ||
          s_rsp_fault !== 2'b00) begin
        errors++;
        $display("FAIL dw32_load_%0d: got v %b %h/%b want 1 %h/00",
          i, s_rsp_valid, s_rsp_rdata, s_rsp_fault, exp[31:0]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int bad;
    @(negedge clk);
    req_valid = 1; req_store = 0; req_funct3 = 3'b010;
    req_addr = 32'h8000_0010;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    checks++;
    if (m_arvalid !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got arvalid %b want 1", m_arvalid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_arvalid, m_rready, req_ready, rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL abort_post: got %b want 0010",
        {m_arvalid, m_rready, req_ready, rsp_valid});
    end
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || m_arvalid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d stray cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [63:0] wd, bus, exp_d;
    logic [1:0]  resp, ef;
    logic [7:0]  es;
    int          awd, wdl, bd, ard, rdl, off, nb;
    bit          issue;
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if ($urandom % 4 != 0)
        f3 = st ? 3'($urandom % 4) : 3'($urandom % 7);
      a = 32'h8000_0000 | ($urandom & 32'hFF);
      nb = nbytes(f3);
      if ($urandom % 4 != 0) a = a & ~(32'(nb) - 32'd1);
      wd = {$urandom, $urandom};
      bus = {$urandom, $urandom};
      resp = 2'($urandom % 4);
      awd = $urandom % 4; wdl = $urandom % 4; bd = $urandom % 3;
      ard = $urandom % 4; rdl = $urandom % 3;
      off = int'(a % 8);
      run_op(st, f3, a, wd, bus, resp, awd, wdl, bd, ard, rdl);
      ef = m_fault(st, f3, a, 64);
      issue = (ef == 2'b00);
      if (issue && resp[1]) ef = 2'b10;
      exp_d = (st || ef != 2'b00) ? 64'h0 : m_load(f3, off, bus, 64);
      checks++;
      if (o_timeout || o_fault !== ef || o_rdata !== exp_d) begin
        errors++;
        $display("FAIL rnd_%0d rsp: got %h/%b want %h/%b st %0d f3 %0d a %h",
          n, o_rdata, o_fault, exp_d, ef, st, f3, a);
      end
      checks++;
      if (o_aw_seen !== (st && issue) || o_ar_seen !== (!st && issue) ||
          o_lat !== (issue ? o_hs + 1 : 1) || !o_pulse_ok) begin
        errors++;
        $display("FAIL rnd_%0d flow: got aw %0d ar %0d lat %0d hs %0d pulse %0d",
          n, o_aw_seen, o_ar_seen, o_lat, o_hs, o_pulse_ok);
      end
      if (st && issue) begin
        es = 8'(((1 << nb) - 1) << off);
        checks++;
        if (o_wdata !== (wd << (8 * off)) || o_wstrb !== es ||
            o_awaddr !== a || o_aw_cnt != awd + 1 ||
            o_w_cnt != wdl + 1) begin
          errors++;
          $display("FAIL rnd_%0d wr: got %h/%h %h aw %0d w %0d want %h/%h %h %0d %0d",
            n, o_wdata, o_wstrb, o_awaddr, o_aw_cnt, o_w_cnt,
            wd << (8 * off), es, a, awd + 1, wdl + 1);
        end
      end
      if (!st && issue) begin
        checks++;
        if (o_araddr !== a) begin
          errors++;
          $display("FAIL rnd_%0d araddr: got %h want %h",
            n, o_araddr, a);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_store = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0;
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0;
    m_rdata = 0;
    s_req_valid = 0; s_req_store = 0; s_req_funct3 = 0;
    s_req_addr = 0; s_req_wdata = 0;
    s_bvalid = 0; s_bresp = 0; s_rvalid = 0; s_rresp = 0;
    s_rdata = 0;
    test_reset();
    test_load_lanes();
    test_store_sh();
    test_store_delay();
    test_faults();
    test_dw32();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
